huff_decoder: RTL and testbench



---
 rtl/huff_pkg.sv | 37 +++
 rtl/huff_code_match.sv | 30 +++
 rtl/huff_decoder.sv | 180 ++++++++++++++++++
 tb/tb_huff_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman decoder: table entry layout,
// FSM states and the 12-bit pad field positions.
package huff_pkg;

    localparam int MAX_CHAR_COUNT = 3;

    typedef enum logic [1:0] {
        LOAD_CHAR,
        LOAD_CODE,
        DECODE
    } huff_state_e;

    typedef struct packed {
        logic [7:0]                chr;
        logic [MAX_CHAR_COUNT-1:0] mask;
        logic [MAX_CHAR_COUNT-1:0] value;
    } huff_code_entry_t;

    // io_in fields
    localparam int IO_VALID   = 11;
    localparam int IO_MODE    = 10;
    localparam int IO_RESTART = 9;

    // io_out fields
    localparam int IO_TABLE_ERR   = 11;
    localparam int IO_CODE_ERR    = 10;
    localparam int IO_TABLE_READY = 9;
    localparam int IO_CHAR_VALID  = 8;

    function automatic int popcount(input logic [MAX_CHAR_COUNT-1:0] m);
        int n;
        n = 0;
        for (int b = 0; b < MAX_CHAR_COUNT; b++) n += int'(m[b]);
        return n;
    endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational codeword lookup: finds the lowest table entry whose length
// and masked value agree with the current accumulator.
module huff_code_match
    import huff_pkg::*;
#(
    parameter int N  = huff_pkg::MAX_CHAR_COUNT,
    parameter int LW = $clog2(N + 1),
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  huff_code_entry_t [N-1:0]              tbl_i,
    input  logic [huff_pkg::MAX_CHAR_COUNT-1:0]   acc_i,
    input  logic [LW-1:0]                         len_i,
    output logic                                  hit_o,
    output logic [IW-1:0]                         hit_idx_o
);

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        // Scan high to low so the lowest matching index is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (len_i == LW'(popcount(tbl_i[i].mask)) &&
                ((acc_i & tbl_i[i].mask) == (tbl_i[i].value & tbl_i[i].mask))) begin
                hit_o     = 1'b1;
                hit_idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/huff_decoder.sv
// Huffman decoder: loads a char/code table, then decodes a serial bitstream.
// Define HUFF_DEC_TABLE_CHECK_EN to validate the table as it is loaded.
module huff_decoder
    import huff_pkg::*;
#(
    // Must equal huff_pkg::MAX_CHAR_COUNT, which sizes the entry mask/value fields.
    parameter int MAX_CHAR_COUNT = huff_pkg::MAX_CHAR_COUNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);

    localparam int N  = MAX_CHAR_COUNT;
    localparam int LW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    huff_state_e             state_q, state_d;
    huff_code_entry_t [N-1:0] tbl_q, tbl_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [N-1:0]            acc_q, acc_d;
    logic [LW-1:0]           len_q, len_d;
    logic [7:0]              char_q, char_d;
    logic                    cv_q, cv_d, rdy_q, rdy_d, cerr_q, cerr_d;

    logic          vld, restart, word0, bit1, stream_en, terr_o;
    logic [N-1:0]  acc_sh;
    logic [LW-1:0] len_inc;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          unused_bits;

    assign vld     = io_in[IO_VALID];
    assign restart = vld & io_in[IO_RESTART];
    assign word0   = vld & ~io_in[IO_MODE] & ~io_in[IO_RESTART];
    assign bit1    = vld &  io_in[IO_MODE] & ~io_in[IO_RESTART];
    assign unused_bits = io_in[8];

    // First received bit ends up as the MSB of the finished codeword.
    assign acc_sh  = {acc_q[N-2:0], io_in[0]};
    assign len_inc = len_q + 1'b1;

    huff_code_match #(.N(N), .LW(LW), .IW(IW)) u_match (
        .tbl_i     (tbl_q),
        .acc_i     (acc_sh),
        .len_i     (len_inc),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

`ifdef HUFF_DEC_TABLE_CHECK_EN
    logic         terr_q, terr_d, code_bad, char_dup;
    logic [N-1:0] cm, cv;

    always_comb begin
        cm       = io_in[N +: N];
        cv       = io_in[N-1:0];
        // Legal masks are contiguous low ones: m != 0 and m & (m+1) == 0.
        code_bad = (cm == '0) || ((cm & (cm + 1'b1)) != '0) || ((cv & ~cm) != '0);
        char_dup = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(idx_q) && tbl_q[i].chr == io_in[7:0]) char_dup = 1'b1;
        end
        terr_d = terr_q;
        if (restart)
            terr_d = 1'b0;
        else if (word0 && ((state_q == LOAD_CHAR && char_dup) ||
                           (state_q == LOAD_CODE && code_bad)))
            terr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) terr_q <= 1'b0;
        else        terr_q <= terr_d;
    end

    assign stream_en = bit1 & ~terr_q;
    assign terr_o    = terr_q;
`else
    assign stream_en = bit1;
    assign terr_o    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= LOAD_CHAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = LOAD_CHAR;
        end else begin
            case (state_q)
                LOAD_CHAR: if (word0) state_d = LOAD_CODE;
                LOAD_CODE: if (word0) state_d = (idx_q == IW'(N - 1)) ? DECODE : LOAD_CHAR;
                DECODE:    state_d = DECODE;
                default:   state_d = LOAD_CHAR;
            endcase
        end
    end

    always_comb begin
        tbl_d  = tbl_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        len_d  = len_q;
        char_d = char_q;
        rdy_d  = rdy_q;
        cv_d   = 1'b0;
        cerr_d = 1'b0;
        if (restart) begin
            // Table contents survive a restart; only the load/decode progress resets.
            idx_d = '0;
            acc_d = '0;
            len_d = '0;
            rdy_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_CHAR: if (word0) tbl_d[idx_q].chr = io_in[7:0];
                LOAD_CODE: if (word0) begin
                    tbl_d[idx_q].mask  = io_in[N +: N];
                    tbl_d[idx_q].value = io_in[N-1:0];
                    if (idx_q == IW'(N - 1)) begin
                        rdy_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DECODE: if (stream_en) begin
                    if (hit) begin
                        char_d = tbl_q[hit_idx].chr;
                        cv_d   = 1'b1;
                        acc_d  = '0;
                        len_d  = '0;
                    end else if (len_inc == LW'(N)) begin
                        cerr_d = 1'b1;
                        acc_d  = '0;
                        len_d  = '0;
                    end else begin
                        acc_d = acc_sh;
                        len_d = len_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_q  <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
            len_q  <= '0;
            char_q <= '0;
            cv_q   <= 1'b0;
            rdy_q  <= 1'b0;
            cerr_q <= 1'b0;
        end else begin
            tbl_q  <= tbl_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            len_q  <= len_d;
            char_q <= char_d;
            cv_q   <= cv_d;
            rdy_q  <= rdy_d;
            cerr_q <= cerr_d;
        end
    end

    assign io_out[7:0]            = char_q;
    assign io_out[IO_CHAR_VALID]  = cv_q;
    assign io_out[IO_TABLE_READY] = rdy_q;
    assign io_out[IO_CODE_ERR]    = cerr_q;
    assign io_out[IO_TABLE_ERR]   = terr_o;

endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: table load, decode, code error, restart,
// async reset, ignored inputs and (build-dependent) table checking.
module tb_huff_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] io_in;
    logic [11:0] io_out;
    int          checks   = 0;
    int          failures = 0;

`ifdef HUFF_DEC_TABLE_CHECK_EN
    localparam logic [11:0] TE = 12'h800;
`else
    localparam logic [11:0] TE = 12'h000;
`endif
    localparam logic [11:0] RST = 12'hA00;

    always #5 clk = ~clk;

    huff_decoder dut (
        .clk    (clk),
        .reset  (reset),
        .io_in  (io_in),
        .io_out (io_out)
    );

    function automatic logic [11:0] wc(input logic [7:0] c);
        return {4'h8, c};
    endfunction

    function automatic logic [11:0] wcode(input logic [2:0] m, input logic [2:0] v);
        return {1'b1, 5'b0, m, v};
    endfunction

    function automatic logic [11:0] wbit(input logic b);
        return {2'b11, 9'b0, b};
    endfunction

    task automatic chk(input string tag, input logic [11:0] exp);
        checks++;
        assert (io_out === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, io_out, exp);
        end
    endtask

    task automatic step(input logic [11:0] w, input string tag, input logic [11:0] exp);
        @(negedge clk);
        io_in = w;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    task automatic load3(input logic [7:0] c0, input logic [2:0] m0, input logic [2:0] v0,
                         input logic [7:0] c1, input logic [2:0] m1, input logic [2:0] v1,
                         input logic [7:0] c2, input logic [2:0] m2, input logic [2:0] v2,
                         input logic [11:0] pre, input logic [11:0] post);
        step(wc(c0),         "load_c0", pre);
        step(wcode(m0, v0),  "load_k0", pre);
        step(wc(c1),         "load_c1", pre);
        step(wcode(m1, v1),  "load_k1", pre);
        step(wc(c2),         "load_c2", pre);
        step(wcode(m2, v2),  "load_k2", post);
    endtask

    initial begin
        io_in = 12'h000;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 chk("reset_state", 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Basic load and decode: a=0, b=10, c=11
        load3(8'h61, 3'b001, 3'b000, 8'h62, 3'b011, 3'b010, 8'h63, 3'b011, 3'b011,
              12'h000, 12'h200);
        step(wbit(0), "dec_a",     12'h361);
        step(wbit(1), "dec_b1",    12'h261);
        step(wbit(0), "dec_b",     12'h362);
        step(wbit(1), "dec_c1",    12'h262);
        step(wbit(1), "dec_c",     12'h363);
        step(12'h000, "idle",      12'h263);

        // Ignored inputs in DECODE
        step(wc(8'h55), "ign_mode0",   12'h263);
        step(12'h4FF,   "ign_novalid", 12'h263);
        step(12'h3FF,   "ign_norst",   12'h263);
        step(wbit(0),   "ign_after_a", 12'h361);

        // Invalid code: masks 011, values 00/01/10; mode-1 word during load ignored
        step(RST,             "rst2",      12'h061);
        step(wc(8'h71),       "l2_c0",     12'h061);
        step(wcode(3, 0),     "l2_k0",     12'h061);
        step(wbit(1),         "l2_ignbit", 12'h061);
        step(wc(8'h72),       "l2_c1",     12'h061);
        step(wcode(3, 1),     "l2_k1",     12'h061);
        step(wc(8'h73),       "l2_c2",     12'h061);
        step(wcode(3, 2),     "l2_ready",  12'h261);
        step(wbit(1),         "err_b1",    12'h261);
        step(wbit(1),         "err_b2",    12'h261);
        step(wbit(1),         "code_err",  12'h661);
        step(wbit(0),         "post_err0", 12'h261);
        step(wbit(0),         "post_err",  12'h371);

        // Mid-stream restart, then a new table decoded from an empty accumulator
        step(wbit(1), "mid_bit",     12'h271);
        step(RST,     "mid_restart", 12'h071);
        load3(8'h41, 3'b001, 3'b001, 8'h42, 3'b011, 3'b000, 8'h43, 3'b011, 3'b000,
              12'h071, 12'h271);
        step(wbit(1), "t3_a",    12'h341);
        step(wbit(0), "t3_b0",   12'h241);
        step(wbit(0), "t3_prio", 12'h342);
        step(12'h000, "t3_idle", 12'h242);

        // Async reset while in LOAD_CODE
        step(RST,         "pre_rst",   12'h042);
        step(wc(8'h61),   "pre_c0",    12'h042);
        step(wcode(1, 0), "pre_k0",    12'h042);
        step(wc(8'h62),   "pre_c1",    12'h042);
        @(negedge clk);
        io_in = 12'h000;
        #2 reset = 1'b0;
        #1 chk("async_reset", 12'h000);
        @(negedge clk) reset = 1'b1;
        load3(8'h61, 3'b001, 3'b000, 8'h62, 3'b011, 3'b010, 8'h63, 3'b011, 3'b011,
              12'h000, 12'h200);
        step(wbit(1), "ar_c1", 12'h200);
        step(wbit(1), "ar_c",  12'h363);

        // Table check: illegal mask 101
        step(RST,         "tc_rst",   12'h063);
        step(wc(8'h61),   "tc_c0",    12'h063);
        step(wcode(5, 0), "tc_mask",  12'h063 | TE);
        step(wc(8'h62),   "tc_c1",    12'h063 | TE);
        step(wcode(3, 2), "tc_k1",    12'h063 | TE);
        step(wc(8'h63),   "tc_c2",    12'h063 | TE);
        step(wcode(3, 3), "tc_ready", 12'h263 | TE);
        step(wbit(1),     "tc_b1",    12'h263 | TE);
        step(wbit(1),     "tc_b2",    (TE != 12'h000) ? 12'hA63 : 12'h363);

        // Table check: duplicate character
        step(RST,         "dup_rst", 12'h063);
        step(wc(8'h61),   "dup_c0",  12'h063);
        step(wcode(1, 0), "dup_k0",  12'h063);
        step(wc(8'h61),   "dup_c1",  12'h063 | TE);
        step(RST,         "dup_clr", 12'h063);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
